// File: rtl/second_level_encoder_stream_if.sv
// ----------------------------------------------------------------------------
// second_level_encoder_stream_if
//   Bundles the data-in and parity-out handshakes of the second-level parity
//   encoder.
//
//   Handshake rule (both directions): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer holds valid and
//   its payload stable until that transfer. The consumer may raise or lower
//   ready at any time.
//
//   Signals
//     in_valid  / in_ready   data symbol handshake (master -> encoder)
//     in_sym    [SYM_W]      data symbol
//     in_last                final symbol of a (possibly shortened) frame
//     out_valid / out_ready  parity symbol handshake (encoder -> master)
//     out_sym   [SYM_W]      parity symbol
//     out_idx   [IDX_W]      parity index of out_sym
//     out_last               last parity of the frame
//
//   Modports
//     master : traffic source/sink around the encoder (testbench, datapath)
//     slave  : the encoder itself
// ----------------------------------------------------------------------------
interface second_level_encoder_stream_if #(
    parameter int SYM_W      = 4,
    parameter int NUM_PARITY = 4
);
    localparam int IDX_W = (NUM_PARITY > 1) ? $clog2(NUM_PARITY) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_idx, out_last
    );
endinterface

// File: rtl/second_level_encoder_stream.sv
// ----------------------------------------------------------------------------
// second_level_encoder_stream
//   Streaming second-level parity encoder over GF(2^SYM_W). Data symbols
//   arrive one per cycle; every accepted symbol d[k] is folded into all
//   NUM_PARITY accumulators as acc[p] ^= d[k] * COEF[p][k]. When the frame
//   ends (NUM_DATA symbols, or an earlier in_last) the parities are emitted
//   serially, index 0 first.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     clr          synchronous clear; aborts the frame, wins over handshakes
//     bus          slave side of second_level_encoder_stream_if
//     busy         frame in progress (symbols accepted or parities pending)
//     o_dbg_state  current FSM state (0 = ACC, 1 = EMIT)
// ----------------------------------------------------------------------------
module second_level_encoder_stream #(
    parameter int                                    SYM_W      = 4,
    parameter logic [SYM_W:0]                        POLY       = 5'h13,
    parameter int                                    NUM_DATA   = 8,
    parameter int                                    NUM_PARITY = 4,
    // COEF[p][k] lives at bit slice (p*NUM_DATA+k)*SYM_W; row p0 sits in the
    // low 32 bits with k=0 in the lowest nibble.
    parameter logic [NUM_PARITY*NUM_DATA*SYM_W-1:0] COEF       =
        128'hC7D8722D_D99FDEBC_8FA3D658_65D6EE57
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    second_level_encoder_stream_if.slave  bus,
    output logic                          busy,
    output logic                          o_dbg_state
);

    localparam int K_W   = $clog2(NUM_DATA);
    localparam int IDX_W = (NUM_PARITY > 1) ? $clog2(NUM_PARITY) : 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [K_W-1:0]   r_k;
    logic [IDX_W-1:0] r_out_idx;
    logic [SYM_W-1:0] r_acc [NUM_PARITY];

    logic [SYM_W-1:0] w_prod [NUM_PARITY];
    logic             w_accept;
    logic             w_frame_end;
    logic             w_out_fire;
    logic             w_out_final;

    // Shift-and-add multiply: walk the bits of b while repeatedly
    // multiplying a by x (shift left, fold the overflow back via POLY).
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] r;
        logic [SYM_W-1:0] sh;
        r  = '0;
        sh = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) r = r ^ sh;
            sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? POLY[SYM_W-1:0] : '0);
        end
        return r;
    endfunction

    // One multiplier per parity row; the coefficient column follows k.
    for (genvar p = 0; p < NUM_PARITY; p++) begin : g_row
        logic [SYM_W-1:0] w_coef;
        assign w_coef    = COEF[(p*NUM_DATA + int'(r_k))*SYM_W +: SYM_W];
        assign w_prod[p] = gf_mul(bus.in_sym, w_coef);
    end

    assign w_accept    = (r_state == ST_ACC) && bus.in_valid;
    assign w_frame_end = (r_k == K_W'(NUM_DATA-1)) || bus.in_last;
    assign w_out_fire  = (r_state == ST_EMIT) && bus.out_ready;
    assign w_out_final = (r_out_idx == IDX_W'(NUM_PARITY-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ACC;
            r_k       <= '0;
            r_out_idx <= '0;
            for (int p = 0; p < NUM_PARITY; p++) r_acc[p] <= '0;
        end else if (clr) begin
            // Clear wins over any handshake presented in the same cycle.
            r_state   <= ST_ACC;
            r_k       <= '0;
            r_out_idx <= '0;
            for (int p = 0; p < NUM_PARITY; p++) r_acc[p] <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        for (int p = 0; p < NUM_PARITY; p++)
                            r_acc[p] <= r_acc[p] ^ w_prod[p];
                        // A shortened frame simply stops here: the missing
                        // symbols are zero and contribute nothing.
                        if (w_frame_end) begin
                            r_k     <= '0;
                            r_state <= ST_EMIT;
                        end else begin
                            r_k <= r_k + K_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_out_fire) begin
                        if (w_out_final) begin
                            for (int p = 0; p < NUM_PARITY; p++) r_acc[p] <= '0;
                            r_out_idx <= '0;
                            r_state   <= ST_ACC;
                        end else begin
                            r_out_idx <= r_out_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    // Outputs decode straight from flops; out_sym is forced to zero when idle.
    assign bus.in_ready  = (r_state == ST_ACC);
    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.out_sym   = (r_state == ST_EMIT) ? r_acc[r_out_idx] : '0;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = (r_state == ST_EMIT) && w_out_final;
    assign busy          = (r_k != '0) || (r_state == ST_EMIT);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_second_level_encoder_stream.sv
// ----------------------------------------------------------------------------
// tb_second_level_encoder_stream
//   Drives frames into second_level_encoder_stream, predicts the parities
//   with an independent GF(2^4) model (carry-less product then long-division
//   reduction) and compares them in a monitor as they leave the block.
// ----------------------------------------------------------------------------
module tb_second_level_encoder_stream;

    localparam int             SYM_W      = 4;
    localparam int             NUM_DATA   = 8;
    localparam int             NUM_PARITY = 4;
    localparam logic [SYM_W:0] POLY       = 5'h13;

    // Coefficient rows written out as plain numbers, k = 0..7.
    int coef_tbl [NUM_PARITY][NUM_DATA] = '{
        '{ 7,  5, 14, 14,  6, 13,  5,  6},
        '{ 8,  5,  6, 13,  3, 10, 15,  8},
        '{12, 11, 14, 13, 15,  9,  9, 13},
        '{13,  2,  2,  7,  8, 13,  7, 12}
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy;
    logic dbg_state;

    always #5 clk = ~clk;

    second_level_encoder_stream_if #(.SYM_W(SYM_W), .NUM_PARITY(NUM_PARITY)) bus ();

    second_level_encoder_stream dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .bus         (bus),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [5:0]       exp_q[$];      // {parity index, parity symbol}
    int               n_tests = 0;
    int               n_fail  = 0;
    int               bp_mode = 0;   // 0 ready, 1 3-low/1-high, 2 random, 3 low
    logic [SYM_W-1:0] frame_buf [NUM_DATA];
    logic [SYM_W-1:0] frame_a   [NUM_DATA];
    logic [SYM_W-1:0] frame_b   [NUM_DATA];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [SYM_W-1:0] ref_mul(input logic [SYM_W-1:0] a,
                                                 input logic [SYM_W-1:0] b);
        logic [2*SYM_W-2:0] prod;
        prod = '0;
        for (int i = 0; i < SYM_W; i++)
            if (b[i]) prod = prod ^ ((2*SYM_W-1)'(a) << i);
        for (int j = 2*SYM_W-2; j >= SYM_W; j--)
            if (prod[j]) prod = prod ^ ((2*SYM_W-1)'(POLY) << (j - SYM_W));
        return prod[SYM_W-1:0];
    endfunction

    task automatic push_expected(input int n);
        logic [SYM_W-1:0] acc;
        for (int p = 0; p < NUM_PARITY; p++) begin
            acc = '0;
            for (int k = 0; k < n; k++)
                acc = acc ^ ref_mul(frame_buf[k], SYM_W'(coef_tbl[p][k]));
            exp_q.push_back({2'(p), acc});
        end
    endtask

    // ---------------- out_ready driver ----------------
    int bp_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = (bp_cnt == 3);
                bp_cnt        = (bp_cnt + 1) % 4;
            end
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic             hold_pend  = 1'b0;
    logic [SYM_W-1:0] hold_sym   = '0;
    logic [1:0]       hold_idx   = '0;
    logic             ready_next = 1'b0;
    logic [5:0]       exp_e;

    always @(negedge clk) begin
        if (rst || clr) begin
            hold_pend  = 1'b0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) begin
                check_eq("in_ready_after_last", bus.in_ready, 1);
                ready_next = 1'b0;
            end
            if (hold_pend) begin
                check_eq("hold_sym", bus.out_sym, hold_sym);
                check_eq("hold_idx", bus.out_idx, hold_idx);
            end
            if (!bus.out_valid)
                check_eq("idle_sym_zero", bus.out_sym, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", bus.out_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("out_sym",  bus.out_sym,  exp_e[3:0]);
                    check_eq("out_idx",  bus.out_idx,  exp_e[5:4]);
                    check_eq("out_last", bus.out_last, exp_e[5:4] == 2'd3);
                    if (bus.out_last) ready_next = 1'b1;
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_sym  = bus.out_sym;
            hold_idx  = bus.out_idx;
        end
    end

    // ---------------- input driver tasks ----------------
    // Tasks start and end at 1 time unit after a rising edge.
    task automatic send_sym(input logic [SYM_W-1:0] s, input logic l);
        int cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_sym   = '0;
    endtask

    task automatic drive_frame(input int n, input int gap_max);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_sym(frame_buf[k], k == n - 1);
        end
    endtask

    task automatic send_frame(input int n, input int gap_max);
        int cyc = 0;
        push_expected(n);
        drive_frame(n, gap_max);
        @(negedge clk);
        check_eq("latency_out_valid", bus.out_valid, 1);
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic load_unit_frame(input logic [SYM_W-1:0] d0);
        for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = '0;
        frame_buf[0] = d0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready",  bus.in_ready,  1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_last",  bus.out_last,  0);
        check_eq("rst_out_sym",   bus.out_sym,   0);
        check_eq("rst_out_idx",   bus.out_idx,   0);
        check_eq("rst_busy",      busy,          0);
        @(posedge clk);
        #1;

        // 1: all-zero full frame
        load_unit_frame('0);
        send_frame(NUM_DATA, 0);

        // 2: unit vector in d[0] -> first coefficient column
        load_unit_frame(4'd1);
        send_frame(NUM_DATA, 0);

        // 3: single-symbol shortened frame
        frame_buf[0] = 4'd2;
        send_frame(1, 0);

        // 4: scenario 2 under periodic backpressure
        bp_mode = 1;
        load_unit_frame(4'd1);
        send_frame(NUM_DATA, 0);
        bp_mode = 0;

        // 5: random frames A, B, A^B with input gaps and random out_ready
        bp_mode = 2;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < NUM_DATA; k++) begin
                frame_a[k] = SYM_W'($urandom_range(0, 15));
                frame_b[k] = SYM_W'($urandom_range(0, 15));
            end
            for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = frame_a[k];
            send_frame(NUM_DATA, 2);
            for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = frame_b[k];
            send_frame(NUM_DATA, 2);
            for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = frame_a[k] ^ frame_b[k];
            send_frame(NUM_DATA, 2);
        end
        for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = SYM_W'($urandom_range(0, 15));
        send_frame($urandom_range(2, NUM_DATA - 2), 1);
        bp_mode = 0;

        // 6a: clr after 5 accepted symbols; the symbol in the clr cycle is dropped
        for (int k = 0; k < 5; k++) send_sym(SYM_W'(k + 3), 1'b0);
        @(negedge clk);
        check_eq("busy_mid_frame", busy, 1);
        @(posedge clk);
        #1;
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sym   = 4'hF;
        bus.in_last  = 1'b1;
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_sym   = '0;
        @(negedge clk);
        check_eq("clr_busy",      busy,          0);
        check_eq("clr_in_ready",  bus.in_ready,  1);
        check_eq("clr_out_valid", bus.out_valid, 0);
        check_eq("clr_state",     dbg_state,     0);
        @(posedge clk);
        #1;
        load_unit_frame(4'd1);
        send_frame(NUM_DATA, 0);

        // 6b: rst while parities are held by backpressure
        bp_mode = 3;
        for (int k = 0; k < NUM_DATA; k++) frame_buf[k] = 4'hA;
        drive_frame(NUM_DATA, 0);
        @(posedge clk);
        #1;
        check_eq("emit_waiting", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_emit_out_valid", bus.out_valid, 0);
        check_eq("rst_emit_out_sym",   bus.out_sym,   0);
        check_eq("rst_emit_busy",      busy,          0);
        check_eq("rst_emit_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bp_mode = 0;
        @(posedge clk);
        #1;
        load_unit_frame(4'd1);
        send_frame(NUM_DATA, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
